// File: rtl/button_conditioner_if.sv
// Signal bundle for the button conditioner.
// The master side drives the raw button level and receives the conditioned outputs.
// The slave side is the conditioner itself.
interface button_conditioner_if;
    logic btn_in;
    logic level;
    logic rise;
    logic fall;
    logic toggle;
    logic busy;

    modport master (
        output btn_in,
        input  level,
        input  rise,
        input  fall,
        input  toggle,
        input  busy
    );

    modport slave (
        input  btn_in,
        output level,
        output rise,
        output fall,
        output toggle,
        output busy
    );
endinterface

// File: rtl/button_conditioner.sv
// Button conditioner: synchronizer -> debounce FSM -> edge/toggle generator.
// A raw asynchronous button level becomes clean, clock-aligned level/rise/toggle
// signals that can drive a downstream flop's d/en pins directly.
// Optional feature macro: BUTTON_CONDITIONER_FALL_EN. When it is defined, the fall
// port carries a one-cycle pulse on every accepted 1->0 transition. When it is not
// defined, fall is tied to 0 and no register backs it.
module button_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic                   level_d;
    logic                   busy_d;
    logic                   level_q;
    logic                   busy_q;
    logic                   rise_q;
    logic                   toggle_q;
    logic                   level_up;

    // Synchronizer chain. This is the only place that sees the raw btn_in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // State register with the stability counter.
    // A reset in the middle of qualification throws away the partial count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LOW;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Entering a WAIT state counts the current sample as the
    // first stable one. Any contrary sample sends the FSM back to its idle state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // State-decoded level and busy. The WAIT states keep the previously accepted level.
    always_comb begin
        level_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state)
            IDLE_LOW:  begin level_d = 1'b0; busy_d = 1'b0; end
            WAIT_HIGH: begin level_d = 1'b0; busy_d = 1'b1; end
            IDLE_HIGH: begin level_d = 1'b1; busy_d = 1'b0; end
            WAIT_LOW:  begin level_d = 1'b1; busy_d = 1'b1; end
            default:   begin level_d = 1'b0; busy_d = 1'b0; end
        endcase
    end

    // level_d can only go 0->1 when WAIT_HIGH is accepted into IDLE_HIGH.
    assign level_up = level_d & ~level_q;

    // Registered outputs. The rise pulse and the toggle flip land in the same
    // cycle that level first shows the new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
            rise_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            busy_q   <= busy_d;
            rise_q   <= level_up;
            toggle_q <= toggle_q ^ level_up;
        end
    end

`ifdef BUTTON_CONDITIONER_FALL_EN
    logic fall_q;

    // Fall pulse, aligned with level dropping after WAIT_LOW is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= ~level_d & level_q;
        end
    end

    assign bus.fall = fall_q;
`else
    assign bus.fall = 1'b0;
`endif

    assign bus.level  = level_q;
    assign bus.busy   = busy_q;
    assign bus.rise   = rise_q;
    assign bus.toggle = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (default parameters: 2 sync stages, 16 stable cycles).
// The stimulus side pushes the expected outputs for each clock edge into a queue.
// The monitor pops one entry after each edge and compares it with the DUT outputs.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef BUTTON_CONDITIONER_FALL_EN
    localparam logic FALL_EN = 1'b1;
`else
    localparam logic FALL_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0] value;
        string      tag;
        int         cycle;
    } exp_t;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic exp_toggle   = 1'b0;

    // Compare {level, rise, fall, toggle, busy} with the required value.
    task automatic check_output(input string tag, input int cyc, input logic [4:0] want);
        logic [4:0] got;
        got = {bus.level, bus.rise, bus.fall, bus.toggle, bus.busy};
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s edge %0d: level/rise/fall/toggle/busy got %b required %b",
                     tag, cyc, got, want);
        end
    endtask

    // Drive btn_in before the next edge and queue the outputs expected after that edge.
    task automatic apply_stimulus(input string tag, input int cyc, input logic b,
                                  input logic lvl, input logic rs, input logic fl,
                                  input logic bsy);
        exp_t e;
        @(negedge clk);
        bus.btn_in = b;
        e.value = {lvl, rs, fl & FALL_EN, exp_toggle, bsy};
        e.tag   = tag;
        e.cycle = cyc;
        sb_q.push_back(e);
    endtask

    // Monitor: the outputs are registered, so one expected entry is presented after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output(e.tag, e.cycle, e.value);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus scenarios. Edge k of a scenario is the k-th rising edge after btn_in is set.
    // With the defaults, level, rise and toggle update after edge 18.
    initial begin
        logic b;
        rst        = 1'b0;
        bus.btn_in = 1'b1;

        // Reset held with btn_in high: every output stays 0.
        for (int k = 0; k < 5; k++)
            apply_stimulus("reset_hold", k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;

        // btn_in already high at release: this is a normal 0->1 acceptance.
        for (int k = 0; k < 25; k++) begin
            if (k == 18) exp_toggle = ~exp_toggle;
            apply_stimulus("release_rise", k, 1'b1, k >= 18, k == 18, 1'b0, k >= 3 && k <= 17);
        end

        // Button released: level drops after edge 18, with a fall pulse if enabled.
        for (int k = 0; k < 25; k++)
            apply_stimulus("release_fall", k, 1'b0, k < 18, 1'b0, k == 18, k >= 3 && k <= 17);

        // Bounce pattern 1x5, 0x3, 1x4, 0x2, then 0: busy only, level never changes.
        for (int k = 0; k < 30; k++) begin
            b = (k <= 4) || (k >= 8 && k <= 11);
            apply_stimulus("bounce", k, b, 1'b0, 1'b0, 1'b0,
                           (k >= 3 && k <= 7) || (k >= 11 && k <= 14));
        end

        // Two clean presses: toggle flips once per press, one rise and one fall each.
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 60; k++) begin
                if (k == 18) exp_toggle = ~exp_toggle;
                apply_stimulus("toggle_press", p * 60 + k, k < 30, k >= 18 && k < 48, k == 18,
                               k == 48, (k >= 3 && k <= 17) || (k >= 33 && k <= 47));
            end
        end

        // Reset in the middle of qualification clears everything at once.
        for (int k = 0; k < 12; k++)
            apply_stimulus("midreset_pre", k, 1'b1, 1'b0, 1'b0, 1'b0, k >= 3);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_toggle = 1'b0;
        #1 check_output("midreset_async", 12, 5'b00000);
        for (int k = 12; k < 14; k++)
            apply_stimulus("midreset_hold", k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 18) exp_toggle = ~exp_toggle;
            apply_stimulus("midreset_rise", k, 1'b1, k >= 18, k == 18, 1'b0, k >= 3 && k <= 17);
        end

        // Bring level back to 0 before the late-bounce case.
        for (int k = 0; k < 25; k++)
            apply_stimulus("return_low", k, 1'b0, k < 18, 1'b0, k == 18, k >= 3 && k <= 17);

        // Late bounce: 15 high samples, 1 low, then stable high. The candidate is dropped
        // at edge 17 and acceptance restarts, so rise lands after edge 34.
        for (int k = 0; k < 40; k++) begin
            if (k == 34) exp_toggle = ~exp_toggle;
            apply_stimulus("late_bounce", k, k != 15, k >= 34, k == 34, 1'b0,
                           (k >= 3 && k <= 17) || (k >= 19 && k <= 33));
        end

        // Let the monitor drain the queue, then make sure nothing was left unchecked.
        repeat (3) @(negedge clk);
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions a raw, asynchronous push-button or switch input into clean, clock-aligned signals for the downstream flip-flop stage.
- Three sections in series:
  - multi-stage synchronizer
  - debounce FSM with stability counter
  - edge/toggle generator
- Outputs drive the DFF `d` and `en` pins directly: the `level` output as data, the `rise` pulse as enable, or `toggle` as a T-style source.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range ≥ 2.
- STABLE_CYCLES, 16, consecutive identical synchronized samples required to accept a new level; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
- btn_in  input  1  raw asynchronous button/switch level.
- level  output  1  debounced, synchronized input level.
- rise  output  1  one-cycle pulse when level goes 0→1.
- fall  output  1  one-cycle pulse when level goes 1→0 (see Optional Feature).
- toggle  output  1  inverts on every rise pulse.
- busy  output  1  high while the FSM is qualifying a candidate transition.

Behaviour:
- Reset (rst=0): synchronizer flops=0, state=IDLE_LOW, counter=0, level=0, rise=0, fall=0, toggle=0, busy=0. Applies immediately and mid-operation; any partially counted transition is discarded.
- Synchronizer: chain of SYNC_STAGES flops; the last stage output is `s`. btn_in is used nowhere else.
- Counter width: $clog2(STABLE_CYCLES+1). Saturation is not needed: the counter clears on every state change.
- FSM states:
  - IDLE_LOW: `s`=1 → WAIT_HIGH, cnt=1 (this sample counts as the first).
  - WAIT_HIGH:
    - `s`=0 → IDLE_LOW, cnt=0 (bounce rejected, no output change).
    - `s`=1 and cnt==STABLE_CYCLES-1 → IDLE_HIGH, cnt=0.
    - otherwise cnt+=1.
  - IDLE_HIGH: `s`=0 → WAIT_LOW, cnt=1.
  - WAIT_LOW: mirror of WAIT_HIGH with `s` inverted; on acceptance → IDLE_LOW.
- Outputs, all registered:
  - level=1 in IDLE_HIGH/WAIT_LOW, 0 otherwise.
  - busy=1 in WAIT_HIGH/WAIT_LOW.
  - rise=1 for exactly the one cycle following the WAIT_HIGH→IDLE_HIGH edge.
  - fall likewise for WAIT_LOW→IDLE_LOW.
  - toggle inverts on the same edge that asserts rise.
- Latency: a clean btn_in step placed before clock edge 0 gives level, rise and toggle updates visible after edge SYNC_STAGES+STABLE_CYCLES. With defaults this is edge 18.
- Boundaries:
  - A bounce on the final qualifying sample rejects the whole candidate; counting restarts from that point.
  - btn_in pulses shorter than one clock period may be missed entirely; this is acceptable.
  - rise and fall are never asserted in the same cycle, and never in consecutive cycles: the minimum spacing is STABLE_CYCLES.
  - After reset release with btn_in already 1, this is treated as a normal 0→1 transition: rise pulses once.

Optional Feature:
- Macro: BUTTON_CONDITIONER_FALL_EN.
- Defined: the fall pulse is generated as described above.
- Undefined: the fall port remains present, tied to 0; the fall register is not implemented. All other behaviour is identical.

Test Plan:
- Reset hold: rst=0 for 5 cycles with btn_in=1 → level=rise=toggle=busy=0 throughout. Release rst, keep btn_in=1 → level=1 and rise=1 for one cycle after edge 18, toggle=1, busy high during edges 3–18.
- Bounce rejection: btn_in pattern 1×5, 0×3, 1×4, 0×2 cycles, then stable 0 → level stays 0, rise never asserted, busy pulses during the 1-runs.
- Release: from level=1, drive btn_in=0 stable → level=0 after edge 18, no rise. fall=1 for one cycle if BUTTON_CONDITIONER_FALL_EN is defined, otherwise fall stays 0.
- Toggle: two clean presses (each 1×30 cycles, 0×30 cycles) → toggle goes 0→1→0, exactly two rise pulses.
- Reset mid-qualification: btn_in=1, assert rst=0 at edge 12 for 2 cycles → all outputs 0 immediately. After release, level rises only after a further full 18 edges.
- Late bounce: btn_in=1 for 15 synchronized samples, 0 for 1, then 1 stable → no rise at the 16th sample; rise occurs 16 samples after the return to 1.
